tpu_c_drain: RTL and testbench



---
 rtl/tpu_pkg.sv | 18 +
 rtl/tpu_lane_serializer.sv | 73 +++++++
 rtl/tpu_c_drain.sv | 127 ++++++++++++
 tb/tb_tpu_c_drain.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: buffer geometry and the C-drain state encoding.
package tpu_pkg;

  localparam int ADDR_BITS     = 16;
  localparam int DATAC_BITS    = 128;
  localparam int LANE_BITS     = 32;
  localparam int LANES         = DATAC_BITS / LANE_BITS;
  localparam int LANE_IDX_BITS = $clog2(LANES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_FIN   = 3'd4
  } drain_state_e;

endpackage

// File: rtl/tpu_lane_serializer.sv
// Holds one C entry and streams it out as LANES beats, lane 0 first,
// keeping tdata/tlast/tvalid stable while the consumer stalls.
module tpu_lane_serializer
  import tpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATAC_BITS-1:0] c_data,
  input  logic                  last_entry,
  input  logic                  tready,
  output logic                  tvalid,
  output logic [LANE_BITS-1:0]  tdata,
  output logic                  tlast,
  output logic                  last_lane_accepted
);

  logic [DATAC_BITS-1:0]    hold_r;
  logic [LANE_IDX_BITS-1:0] lane_r;
  logic                     tvalid_r;
  logic                     accept_s;
  logic                     final_lane_s;

  // Handshake decode for the lane currently on the bus.
  always_comb begin
    accept_s     = tvalid_r & tready;
    final_lane_s = (lane_r == LANE_IDX_BITS'(LANES - 1));
  end

  // Entry capture, lane advance on each accepted beat, valid drop after the final lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_r   <= '0;
      lane_r   <= '0;
      tvalid_r <= 1'b0;
    end else if (load) begin
      hold_r   <= c_data;
      lane_r   <= '0;
      tvalid_r <= 1'b1;
    end else if (accept_s) begin
      lane_r <= lane_r + LANE_IDX_BITS'(1);
      if (final_lane_s) begin
        tvalid_r <= 1'b0;
      end else begin
        tvalid_r <= 1'b1;
      end
    end else begin
      hold_r   <= hold_r;
      lane_r   <= lane_r;
      tvalid_r <= tvalid_r;
    end
  end

  // Lane select from the holding register; only registered state feeds the bus.
  always_comb begin
    tdata = '0;
    case (lane_r)
      2'd0:    tdata = hold_r[31:0];
      2'd1:    tdata = hold_r[63:32];
      2'd2:    tdata = hold_r[95:64];
      2'd3:    tdata = hold_r[127:96];
      default: tdata = '0;
    endcase
  end

  // Stream status toward the bus and the drain FSM.
  always_comb begin
    tvalid             = tvalid_r;
    tlast              = tvalid_r & final_lane_s & last_entry;
    last_lane_accepted = accept_s & final_lane_s;
  end

endmodule

// File: rtl/tpu_c_drain.sv
// Drains a run of C buffer entries onto a 32-bit valid/ready stream.
module tpu_c_drain
  import tpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  C_base,
  input  logic [ADDR_BITS-1:0]  length,
  output logic                  C_rd_en,
  output logic [ADDR_BITS-1:0]  C_index,
  input  logic [DATAC_BITS-1:0] C_data_out,
  output logic                  sm_tvalid,
  output logic [LANE_BITS-1:0]  sm_tdata,
  output logic                  sm_tlast,
  input  logic                  sm_tready,
  output logic                  busy,
  output logic                  done
);

  drain_state_e         state_r;
  drain_state_e         state_s;
  logic [ADDR_BITS-1:0] base_r;
  logic [ADDR_BITS-1:0] len_r;
  logic [ADDR_BITS-1:0] ptr_r;
  logic                 c_rd_en_r;
  logic [ADDR_BITS-1:0] c_index_r;
  logic                 busy_r;
  logic                 done_r;
  logic [ADDR_BITS-1:0] fetch_addr_s;
  logic                 last_entry_s;
  logic                 last_lane_accepted_s;

  // Next state; the pointer compare uses the full address width so length 2^N-1 works.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && (length != '0)) begin
          state_s = ST_FETCH;
        end else if (start) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: state_s = ST_LOAD;
      ST_LOAD:  state_s = ST_SEND;
      ST_SEND: begin
        if (last_lane_accepted_s && ((ptr_r + ADDR_BITS'(1)) == len_r)) begin
          state_s = ST_FIN;
        end else if (last_lane_accepted_s) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_FIN:   state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Address of the entry about to be fetched (first entry comes straight off the start inputs).
  always_comb begin
    if (state_r == ST_IDLE) begin
      fetch_addr_s = C_base;
    end else begin
      fetch_addr_s = base_r + ptr_r + ADDR_BITS'(1);
    end
    last_entry_s = (ptr_r == (len_r - ADDR_BITS'(1)));
  end

  // State, drain parameters, entry pointer and registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      base_r    <= '0;
      len_r     <= '0;
      ptr_r     <= '0;
      c_rd_en_r <= 1'b0;
      c_index_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && start) begin
        base_r <= C_base;
        len_r  <= length;
        ptr_r  <= '0;
      end else if ((state_r == ST_SEND) && last_lane_accepted_s) begin
        ptr_r <= ptr_r + ADDR_BITS'(1);
      end else begin
        ptr_r <= ptr_r;
      end
      c_rd_en_r <= (state_s == ST_FETCH);
      if (state_s == ST_FETCH) begin
        c_index_r <= fetch_addr_s;
      end else begin
        c_index_r <= c_index_r;
      end
      busy_r <= (state_s == ST_FETCH) || (state_s == ST_LOAD) || (state_s == ST_SEND);
      done_r <= (state_s == ST_FIN);
    end
  end

  tpu_lane_serializer u_ser (
    .clk                (clk),
    .rst_n              (rst_n),
    .load               (state_r == ST_LOAD),
    .c_data             (C_data_out),
    .last_entry         (last_entry_s),
    .tready             (sm_tready),
    .tvalid             (sm_tvalid),
    .tdata              (sm_tdata),
    .tlast              (sm_tlast),
    .last_lane_accepted (last_lane_accepted_s)
  );

  // Drive ports from the registered control state.
  always_comb begin
    C_rd_en = c_rd_en_r;
    C_index = c_index_r;
    busy    = busy_r;
    done    = done_r;
  end

endmodule

// File: tb/tb_tpu_c_drain.sv
// Scoreboard bench for tpu_c_drain: a driver queues expected beats/reads,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_tpu_c_drain;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  C_base = 16'd0;
  logic [15:0]  length = 16'd0;
  logic         C_rd_en;
  logic [15:0]  C_index;
  logic [127:0] C_data_out = 128'd0;
  logic         sm_tvalid;
  logic [31:0]  sm_tdata;
  logic         sm_tlast;
  logic         sm_tready = 1'b0;
  logic         busy;
  logic         done;

  logic [127:0] mem [0:65535];
  beat_t        exp_q[$];
  logic [15:0]  rd_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int pat_idx = 0;
  int beats = 0, rd_cnt = 0, tlast_cnt = 0, done_cnt = 0;
  int first_rd_cyc = -1, first_valid_cyc = -1, done_cyc = -1;
  bit          stalled_prev = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        prev_last = 1'b0;

  tpu_c_drain dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .C_base     (C_base),
    .length     (length),
    .C_rd_en    (C_rd_en),
    .C_index    (C_index),
    .C_data_out (C_data_out),
    .sm_tvalid  (sm_tvalid),
    .sm_tdata   (sm_tdata),
    .sm_tlast   (sm_tlast),
    .sm_tready  (sm_tready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // C buffer model: data appears the cycle after the read strobe.
  always @(posedge clk) if (C_rd_en) C_data_out <= mem[C_index];

  // Downstream ready generator: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 driver-controlled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: sm_tready = 1'b1;
      1: begin
        sm_tready = (pat_idx == 0) || (pat_idx == 3);
        pat_idx = (pat_idx + 1) % 4;
      end
      2: sm_tready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares reads, beats, stall stability and done against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (C_rd_en) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check("read_while_valid", sm_tvalid, 0);
        if (rd_q.size() == 0) check("unexpected_read_count", rd_cnt, 0);
        else check("read_index", C_index, rd_q.pop_front());
      end
      if (stalled_prev) begin
        check("stall_valid", sm_tvalid, 1);
        check("stall_data", sm_tdata, prev_data);
        check("stall_last", sm_tlast, prev_last);
      end
      if (sm_tvalid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        check("busy_in_send", busy, 1);
      end
      if (sm_tvalid && sm_tready) begin
        beats++;
        if (sm_tlast) tlast_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat_count", beats, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", sm_tdata, e.data);
          check("beat_last", sm_tlast, e.last);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
      stalled_prev = sm_tvalid && !sm_tready;
      prev_data = sm_tdata;
      prev_last = sm_tlast;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Reference model: which entries get read and which beats come out, in order.
  task automatic expect_drain(input logic [15:0] base, input logic [15:0] len);
    for (int i = 0; i < int'(len); i++) begin
      logic [15:0]  a;
      logic [127:0] w;
      beat_t        b;
      a = base + 16'(i);
      w = mem[a];
      rd_q.push_back(a);
      for (int l = 0; l < 4; l++) begin
        b.data = w[l*32 +: 32];
        b.last = (i == int'(len) - 1) && (l == 3);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic clear_stats();
    beats = 0; rd_cnt = 0; tlast_cnt = 0; done_cnt = 0;
    first_rd_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
  endtask

  task automatic run_drain(input logic [15:0] base, input logic [15:0] len, input int mode,
                           input bit fill, input bit second_start, input bit check_lat);
    int c0;
    int t;
    if (fill) begin
      for (int i = 0; i < int'(len); i++)
        mem[16'(base + 16'(i))] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    rdy_mode = mode;
    pat_idx = 0;
    @(posedge clk);
    clear_stats();
    expect_drain(base, len);
    #1;
    start = 1'b1; C_base = base; length = len;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; C_base = 16'($urandom()); length = 16'($urandom_range(1, 9));
    if (second_start) begin
      repeat (4) @(posedge clk);
      #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", done_cnt, 1);
    repeat (4) @(posedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("beat_count", beats, 4 * int'(len));
    check("read_count", rd_cnt, int'(len));
    check("tlast_count", tlast_cnt, (len != 16'd0) ? 1 : 0);
    check("beats_left", exp_q.size(), 0);
    check("reads_left", rd_q.size(), 0);
    check("busy_after", busy, 0);
    if (check_lat) begin
      if (len == 16'd0) begin
        check("done_latency", done_cyc, c0 + 1);
      end else begin
        check("read_latency", first_rd_cyc, c0 + 1);
        check("valid_latency", first_valid_cyc, c0 + 3);
        check("done_latency", done_cyc, c0 + 6 * int'(len) + 1);
      end
    end
    exp_q.delete();
    rd_q.delete();
  endtask

  initial begin
    int t;
    logic [15:0] b;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", sm_tvalid, 0);
    check("rst_tlast", sm_tlast, 0);
    check("rst_tdata", sm_tdata, 0);
    check("rst_rd_en", C_rd_en, 0);
    check("rst_index", C_index, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    // Single entry with a known pattern.
    mem[16'h0010] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    run_drain(16'h0010, 16'd1, 0, 1'b0, 1'b0, 1'b1);
    // Three entries back to back.
    run_drain(16'h0000, 16'd3, 0, 1'b1, 1'b0, 1'b1);
    // Stalling consumer.
    run_drain(16'h0200, 16'd2, 1, 1'b1, 1'b0, 1'b0);
    // Zero-length drain.
    run_drain(16'h0300, 16'd0, 0, 1'b1, 1'b0, 1'b1);
    // Address wrap plus an ignored start while busy.
    run_drain(16'hFFFF, 16'd2, 0, 1'b1, 1'b1, 1'b1);

    // Reset during a stalled beat (lane 1 of entry 1).
    b = 16'($urandom());
    rdy_mode = 3;
    sm_tready = 1'b1;
    @(posedge clk);
    clear_stats();
    for (int i = 0; i < 4; i++) mem[16'(b + 16'(i))] = {$urandom(), $urandom(), $urandom(), $urandom()};
    expect_drain(b, 16'd4);
    #1; start = 1'b1; C_base = b; length = 16'd4;
    @(posedge clk); #1; start = 1'b0;
    t = 0;
    while (beats < 5 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("reach_lane1", beats, 5);
    #1; sm_tready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", sm_tvalid, 1);
    @(posedge clk); #1;
    check("post_rst_tvalid", sm_tvalid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_tlast", sm_tlast, 0);
    rst_n = 1'b1;
    exp_q.delete();
    rd_q.delete();
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt, 0);
    check("no_tlast_after_rst", tlast_cnt, 0);
    run_drain(16'($urandom()), 16'd1, 0, 1'b1, 1'b0, 1'b1);

    // Randomised drains.
    for (int k = 0; k < 8; k++) begin
      int m;
      m = $urandom_range(0, 2);
      run_drain(16'($urandom()), 16'($urandom_range(1, 5)), m, 1'b1, 1'b0, m == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
